// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_packer
//  Description : Packs 0..16 MSB-first encoder bits per cycle into a
//                continuous stream of 16-bit words. Ready/valid on both
//                sides; flush emits the zero-padded final word marked last.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bits_in,
    input  logic [4:0]  bits_count,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        flush_in,
    output logic [15:0] word_out,
    output logic [4:0]  word_bits,
    output logic        word_last,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        flush_busy,
    output logic [15:0] words_emitted
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [4:0] c_WORD_BITS = 5'd16;

    logic [0:0]  r_state;
    logic [31:0] r_acc;
    logic [4:0]  r_fill;
    logic [15:0] r_word_out;
    logic [4:0]  r_word_bits;
    logic        r_word_last;
    logic        r_word_valid;
    logic [15:0] r_words_emitted;

    logic [4:0]  w_cnt;
    logic        w_load_ok;
    logic        w_handshake;
    logic        w_last_hs;
    logic        w_emit;
    logic        w_flush_emit;
    logic        w_ready;
    logic        w_accept;
    logic [4:0]  w_post_fill;
    logic [31:0] w_post_acc;
    logic [15:0] w_field;
    logic [31:0] w_ins;

    // Out-of-range counts saturate to a full 16-bit field.
    assign w_cnt       = (bits_count > c_WORD_BITS) ? c_WORD_BITS : bits_count;

    assign w_load_ok   = !r_word_valid || word_ready;
    assign w_handshake = r_word_valid && word_ready;
    assign w_last_hs   = w_handshake && r_word_last;

    // fill >= 16 is exactly fill[4] since fill never exceeds 31.
    assign w_emit      = r_fill[4] && w_load_ok;

    // Once the last word is pending, the flush must not load another word
    // while that one is being handshaked.
    assign w_flush_emit = (r_state == ST_FLUSH) && !r_fill[4] && w_load_ok
                          && !(r_word_valid && r_word_last);

    assign w_ready     = (r_state == ST_RUN) && (!r_fill[4] || w_emit);
    assign w_accept    = valid_in && w_ready;

    // Accumulator view after this cycle's emit, if any.
    assign w_post_fill = w_emit ? (r_fill - c_WORD_BITS) : r_fill;
    assign w_post_acc  = w_emit ? {r_acc[15:0], 16'h0000} : r_acc;

    // Keep only the counted top bits so acc stays zero below fill.
    assign w_field     = bits_in & ~(16'hFFFF >> w_cnt);
    assign w_ins       = {w_field, 16'h0000} >> w_post_fill;

    // Accumulator, output word register, flush state and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_acc           <= 32'h0;
            r_fill          <= 5'd0;
            r_word_out      <= 16'h0;
            r_word_bits     <= 5'd0;
            r_word_last     <= 1'b0;
            r_word_valid    <= 1'b0;
            r_words_emitted <= 16'h0;
        end else begin
            if (w_flush_emit) begin
                r_acc  <= 32'h0;
                r_fill <= 5'd0;
            end else if (w_accept) begin
                r_acc  <= w_post_acc | w_ins;
                r_fill <= w_post_fill + w_cnt;
            end else begin
                r_acc  <= w_post_acc;
                r_fill <= w_post_fill;
            end

            if (w_emit) begin
                r_word_out   <= r_acc[31:16];
                r_word_bits  <= c_WORD_BITS;
                r_word_last  <= 1'b0;
                r_word_valid <= 1'b1;
            end else if (w_flush_emit) begin
                r_word_out   <= r_acc[31:16];
                r_word_bits  <= r_fill;
                r_word_last  <= 1'b1;
                r_word_valid <= 1'b1;
            end else if (w_handshake) begin
                r_word_valid <= 1'b0;
            end

            if ((r_state == ST_RUN) && flush_in) begin
                r_state <= ST_FLUSH;
            end else if (w_last_hs) begin
                r_state <= ST_RUN;
            end

            if (w_last_hs) begin
                r_words_emitted <= 16'h0;
            end else if (w_handshake) begin
                r_words_emitted <= r_words_emitted + 16'd1;
            end
        end
    end

    assign ready_in      = w_ready;
    assign word_out      = r_word_out;
    assign word_bits     = r_word_bits;
    assign word_last     = r_word_last;
    assign word_valid    = r_word_valid;
    assign flush_busy    = (r_state == ST_FLUSH);
    assign words_emitted = r_words_emitted;

endmodule
`default_nettype wire
